// File: rtl/instr_sequencer_if.sv
// Issue channel between the instruction sequencer and the matrix coprocessor.
// The sequencer offers an instruction with valid/ready, then waits for a done pulse.
interface instr_sequencer_if #(
  parameter int INSTR_W = 22
);
  logic [INSTR_W-1:0] instr_out;
  logic               instr_valid;
  logic               cop_ready;
  logic               cop_done;

  modport master (
    output instr_out,
    output instr_valid,
    input  cop_ready,
    input  cop_done
  );

  modport slave (
    input  instr_out,
    input  instr_valid,
    output cop_ready,
    output cop_done
  );
endinterface

// File: rtl/instr_sequencer.sv
// Program RAM plus a four-state issue FSM that feeds the matrix coprocessor one
// instruction per step request, or back-to-back while auto_run is held.
module instr_sequencer #(
  parameter int INSTR_W = 22,
  parameter int DEPTH   = 30,
  parameter int ADDR_W  = 5,
  parameter int TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               prog_we_i,
  input  logic [ADDR_W-1:0]  prog_addr_i,
  input  logic [INSTR_W-1:0] prog_data_i,
  input  logic               step_in_i,
  input  logic               auto_run_i,
  input  logic               err_clr_i,
  output logic               busy_o,
  output logic [ADDR_W-1:0]  pc_out_o,
  output logic               timeout_err_o,
  instr_sequencer_if.master  cop
);

  localparam int                CNT_W     = $clog2(TIMEOUT);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT
  } state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [CNT_W-1:0]   waitCnt_q, waitCnt_d;
  logic               timeoutErr_q, timeoutErr_d;
  logic               step_q;
  logic               stepEdge;

  logic [INSTR_W-1:0] mem [DEPTH];

  // Writes beyond the last program word are dropped rather than aliased.
  always_ff @(posedge clk) begin
    if (prog_we_i && (prog_addr_i <= LAST_ADDR)) begin
      mem[prog_addr_i] <= prog_data_i;
    end
  end

  assign stepEdge = step_in_i & ~step_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    waitCnt_d    = waitCnt_q;
    timeoutErr_d = timeoutErr_q & ~err_clr_i;

    case (state_q)
      S_IDLE: begin
        if (stepEdge || auto_run_i) begin
          state_d = S_FETCH;
        end
      end
      // The RAM word is captured at the FETCH edge, so a write landing on the same
      // edge is not yet visible and the old word is issued.
      S_FETCH: begin
        instr_d = mem[pc_q];
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (cop.cop_ready) begin
          state_d   = S_WAIT;
          waitCnt_d = '0;
        end
      end
      S_WAIT: begin
        if (cop.cop_done) begin
          state_d = S_IDLE;
          pc_d    = (pc_q == LAST_ADDR) ? '0 : pc_q + 1'b1;
        end else if (waitCnt_q == CNT_LAST) begin
          state_d      = S_IDLE;
          timeoutErr_d = 1'b1;
        end else begin
          waitCnt_d = waitCnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pc_q         <= '0;
      instr_q      <= '0;
      waitCnt_q    <= '0;
      timeoutErr_q <= 1'b0;
      step_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      waitCnt_q    <= waitCnt_d;
      timeoutErr_q <= timeoutErr_d;
      step_q       <= step_in_i;
    end
  end

  assign cop.instr_out   = instr_q;
  assign cop.instr_valid = (state_q == S_ISSUE);
  assign busy_o          = (state_q != S_IDLE);
  assign pc_out_o        = pc_q;
  assign timeout_err_o   = timeoutErr_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: a shadow program model feeds a queue of
// expected instructions that are popped as the sequencer offers them.
module tb_instr_sequencer;

  localparam int INSTR_W = 22;
  localparam int DEPTH   = 30;
  localparam int ADDR_W  = 5;
  localparam int TIMEOUT = 1024;

  logic               clk;
  logic               rst;
  logic               progWe;
  logic [ADDR_W-1:0]  progAddr;
  logic [INSTR_W-1:0] progData;
  logic               stepIn;
  logic               autoRun;
  logic               errClr;
  logic               busy;
  logic [ADDR_W-1:0]  pcOut;
  logic               timeoutErr;

  instr_sequencer_if #(.INSTR_W(INSTR_W)) bus ();

  instr_sequencer #(
    .INSTR_W(INSTR_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .prog_we_i    (progWe),
    .prog_addr_i  (progAddr),
    .prog_data_i  (progData),
    .step_in_i    (stepIn),
    .auto_run_i   (autoRun),
    .err_clr_i    (errClr),
    .busy_o       (busy),
    .pc_out_o     (pcOut),
    .timeout_err_o(timeoutErr),
    .cop          (bus)
  );

  int                 errors = 0;
  int                 checks = 0;
  int                 cyc = 0;
  int                 lastValidCyc = -1;
  int                 pcModel = 0;
  logic [INSTR_W-1:0] model [DEPTH];
  logic [INSTR_W-1:0] expQ [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic int nextPc(input int pc);
    return (pc == DEPTH - 1) ? 0 : pc + 1;
  endfunction

  task automatic writeProg(input int addr, input logic [INSTR_W-1:0] data);
    progWe   = 1'b1;
    progAddr = ADDR_W'(addr);
    progData = data;
    tick();
    progWe   = 1'b0;
  endtask

  // One step pulse; the offer must appear two edges after the pulse is driven.
  task automatic applyStimulus();
    expQ.push_back(model[pcModel]);
    stepIn = 1'b1;
    tick();
    stepIn = 1'b0;
    checkOutput("fetch_busy", busy, 1);
    checkOutput("fetch_valid", bus.instr_valid, 0);
    tick();
    checkOutput("step_latency", bus.instr_valid, 1);
  endtask

  task automatic serviceIssue(input int holdCycles, input bit writeInHold,
                              input int doneDelay, input bit checkGap, input bit dropAuto);
    int                 waited = 0;
    logic [INSTR_W-1:0] expInstr;
    logic [INSTR_W-1:0] held;
    while (!bus.instr_valid && waited < 12) begin
      tick();
      waited++;
    end
    checkOutput("issue_valid", bus.instr_valid, 1);
    checkOutput("queue_nonempty", expQ.size() != 0, 1);
    expInstr = (expQ.size() != 0) ? expQ.pop_front() : '0;
    checkOutput("issue_instr", bus.instr_out, expInstr);
    if (checkGap) checkOutput("auto_gap", cyc - lastValidCyc, 4);
    lastValidCyc = cyc;
    if (dropAuto) autoRun = 1'b0;
    held = bus.instr_out;
    for (int i = 0; i < holdCycles; i++) begin
      bus.cop_ready = 1'b0;
      if (writeInHold && i == 0) begin
        model[pcModel] = model[pcModel] ^ 22'h3FFFFF;
        progWe   = 1'b1;
        progAddr = ADDR_W'(pcModel);
        progData = model[pcModel];
      end
      tick();
      progWe = 1'b0;
      checkOutput("hold_valid", bus.instr_valid, 1);
      checkOutput("hold_instr", bus.instr_out, held);
      checkOutput("hold_err", timeoutErr, 0);
    end
    bus.cop_ready = 1'b1;
    tick();
    bus.cop_ready = 1'b0;
    checkOutput("wait_valid", bus.instr_valid, 0);
    checkOutput("wait_busy", busy, 1);
    for (int i = 1; i < doneDelay; i++) tick();
    bus.cop_done = 1'b1;
    tick();
    bus.cop_done = 1'b0;
    pcModel = nextPc(pcModel);
    checkOutput("done_busy", busy, 0);
    checkOutput("done_pc", pcOut, pcModel);
  endtask

  initial begin
    logic [INSTR_W-1:0] oldWord;
    rst = 1'b1;
    progWe = 1'b0;
    progAddr = '0;
    progData = '0;
    stepIn = 1'b0;
    autoRun = 1'b0;
    errClr = 1'b0;
    bus.cop_ready = 1'b0;
    bus.cop_done = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_pc", pcOut, 0);
    checkOutput("rst_valid", bus.instr_valid, 0);
    checkOutput("rst_instr", bus.instr_out, 0);
    checkOutput("rst_err", timeoutErr, 0);

    for (int i = 0; i < DEPTH; i++) model[i] = INSTR_W'((i * 32'h2B5A3) ^ 32'h1C0F0);
    model[0] = 22'h000042;
    model[1] = 22'h000003;
    for (int i = 0; i < DEPTH; i++) writeProg(i, model[i]);
    writeProg(30, 22'h2AAAAA);
    writeProg(31, 22'h155555);

    $display("[TB] single step");
    applyStimulus();
    serviceIssue(0, 1'b0, 2, 1'b0, 1'b0);

    $display("[TB] ready withheld in ISSUE");
    applyStimulus();
    serviceIssue(7, 1'b1, 1, 1'b0, 1'b0);

    $display("[TB] async reset during WAIT");
    applyStimulus();
    checkOutput("rw_instr", bus.instr_out, expQ.pop_front());
    bus.cop_ready = 1'b1;
    tick();
    bus.cop_ready = 1'b0;
    checkOutput("rw_busy_pre", busy, 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("rw_busy", busy, 0);
    checkOutput("rw_pc", pcOut, 0);
    checkOutput("rw_valid", bus.instr_valid, 0);
    checkOutput("rw_instr0", bus.instr_out, 0);
    checkOutput("rw_err", timeoutErr, 0);
    @(negedge clk);
    rst = 1'b0;
    pcModel = 0;
    tick();

    $display("[TB] auto run over full program");
    autoRun = 1'b1;
    lastValidCyc = -1;
    for (int k = 0; k <= DEPTH; k++) begin
      expQ.push_back(model[pcModel]);
      serviceIssue(0, 1'b0, 1, k > 0, k == DEPTH);
    end
    tick();
    tick();
    tick();
    checkOutput("auto_stop_busy", busy, 0);
    checkOutput("auto_stop_valid", bus.instr_valid, 0);
    checkOutput("auto_stop_pc", pcOut, 1);

    $display("[TB] done timeout");
    applyStimulus();
    checkOutput("to_instr", bus.instr_out, expQ.pop_front());
    bus.cop_ready = 1'b1;
    tick();
    bus.cop_ready = 1'b0;
    for (int i = 0; i < TIMEOUT - 1; i++) tick();
    checkOutput("to_edge_busy", busy, 1);
    checkOutput("to_edge_err", timeoutErr, 0);
    tick();
    checkOutput("to_err", timeoutErr, 1);
    checkOutput("to_busy", busy, 0);
    checkOutput("to_pc", pcOut, pcModel);
    bus.cop_done = 1'b1;
    tick();
    bus.cop_done = 1'b0;
    checkOutput("idle_done_pc", pcOut, pcModel);
    checkOutput("idle_done_busy", busy, 0);
    errClr = 1'b1;
    tick();
    errClr = 1'b0;
    checkOutput("err_clr", timeoutErr, 0);

    $display("[TB] ignored done and steps");
    applyStimulus();
    checkOutput("ig_instr", bus.instr_out, expQ.pop_front());
    bus.cop_ready = 1'b1;
    bus.cop_done = 1'b1;
    tick();
    bus.cop_ready = 1'b0;
    bus.cop_done = 1'b0;
    checkOutput("ig_accept_done_busy", busy, 1);
    checkOutput("ig_accept_done_pc", pcOut, pcModel);
    for (int i = 0; i < 3; i++) begin
      stepIn = 1'b1;
      tick();
      stepIn = 1'b0;
      tick();
    end
    checkOutput("ig_step_busy", busy, 1);
    checkOutput("ig_step_valid", bus.instr_valid, 0);
    bus.cop_done = 1'b1;
    tick();
    bus.cop_done = 1'b0;
    pcModel = nextPc(pcModel);
    checkOutput("ig_done_pc", pcOut, pcModel);
    for (int i = 0; i < 4; i++) tick();
    checkOutput("ig_no_issue_busy", busy, 0);
    checkOutput("ig_no_issue_valid", bus.instr_valid, 0);

    $display("[TB] write during FETCH");
    oldWord = model[pcModel];
    expQ.push_back(oldWord);
    stepIn = 1'b1;
    tick();
    stepIn = 1'b0;
    checkOutput("wf_fetch_busy", busy, 1);
    progWe = 1'b1;
    progAddr = ADDR_W'(pcModel);
    progData = oldWord ^ 22'h155AA5;
    model[pcModel] = progData;
    tick();
    progWe = 1'b0;
    serviceIssue(0, 1'b0, 1, 1'b0, 1'b0);
    checkOutput("queue_empty", expQ.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
